sgdmac_axi_mem_slave: RTL and testbench

- AXI3 32-bit responder memory: the far end of the SGDMAC AXI master port; accepts AR/R and AW/W/B traffic from the DMA engine.
- Independent read and write engines, each one outstanding burst, in-order, INCR bursts up to 16 beats.
- Backed by an internal word-addressed flop array.
- Used as the system-side memory in block-level DMA simulation and the FPGA smoke build.

---
 rtl/sgdmac_axi_mem_slave_if.sv | 68 ++++++
 rtl/sgdmac_axi_mem_slave.sv | 172 +++++++++++++++++
 tb/tb_sgdmac_axi_mem_slave.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sgdmac_axi_mem_slave_if.sv
// ============================================================================
// Module      : sgdmac_axi_mem_slave_if
// Description : AXI3 32-bit AW/W/B/AR/R bundle between the SGDMAC master and
//               the responder memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sgdmac_axi_mem_slave_if;
  logic [3:0]  awid_i;
  logic [31:0] awaddr_i;
  logic [3:0]  awlen_i;
  logic [2:0]  awsize_i;
  logic [1:0]  awburst_i;
  logic        awvalid_i;
  logic        awready_o;
  logic [3:0]  wid_i;
  logic [31:0] wdata_i;
  logic [3:0]  wstrb_i;
  logic        wlast_i;
  logic        wvalid_i;
  logic        wready_o;
  logic [3:0]  bid_o;
  logic [1:0]  bresp_o;
  logic        bvalid_o;
  logic        bready_i;
  logic [3:0]  arid_i;
  logic [31:0] araddr_i;
  logic [3:0]  arlen_i;
  logic [2:0]  arsize_i;
  logic [1:0]  arburst_i;
  logic        arvalid_i;
  logic        arready_o;
  logic [3:0]  rid_o;
  logic [31:0] rdata_o;
  logic [1:0]  rresp_o;
  logic        rlast_o;
  logic        rvalid_o;
  logic        rready_i;

  modport slave (
    input  awid_i, awaddr_i, awlen_i, awsize_i, awburst_i, awvalid_i,
    output awready_o,
    input  wid_i, wdata_i, wstrb_i, wlast_i, wvalid_i,
    output wready_o,
    output bid_o, bresp_o, bvalid_o,
    input  bready_i,
    input  arid_i, araddr_i, arlen_i, arsize_i, arburst_i, arvalid_i,
    output arready_o,
    output rid_o, rdata_o, rresp_o, rlast_o, rvalid_o,
    input  rready_i
  );

  modport master (
    output awid_i, awaddr_i, awlen_i, awsize_i, awburst_i, awvalid_i,
    input  awready_o,
    output wid_i, wdata_i, wstrb_i, wlast_i, wvalid_i,
    input  wready_o,
    input  bid_o, bresp_o, bvalid_o,
    output bready_i,
    output arid_i, araddr_i, arlen_i, arsize_i, arburst_i, arvalid_i,
    input  arready_o,
    input  rid_o, rdata_o, rresp_o, rlast_o, rvalid_o,
    output rready_i
  );
endinterface

`default_nettype wire

// File: rtl/sgdmac_axi_mem_slave.sv
// ============================================================================
// Module      : sgdmac_axi_mem_slave
// Description : AXI3 32-bit responder memory with independent single-burst
//               read and write engines over a word-addressed flop array.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sgdmac_axi_mem_slave #(
  parameter int          MEM_AW    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  sgdmac_axi_mem_slave_if.slave axi
);

  localparam int          c_depth  = 2 ** MEM_AW;
  localparam logic [29:0] c_base_w = BASE_ADDR[31:2];

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

  logic [31:0] r_mem [c_depth];

  // write engine state
  wstate_t     r_wstate;
  logic [3:0]  r_wid, r_wlen, r_wcnt, r_bid;
  logic [29:0] r_wwaddr;
  logic        r_wburst_err, r_wsticky;
  logic [1:0]  r_bresp;

  // read engine state
  rstate_t     r_rstate;
  logic [3:0]  r_rid, r_rlen, r_rcnt;
  logic [29:0] r_rwaddr;
  logic        r_rburst_err, r_rvalid, r_rlast;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;

  logic [29:0]       w_wwoff, w_rsel, w_rwoff;
  logic              w_wrange, w_wlast_beat, w_wbeat_err, w_mem_we, w_aw_err;
  logic              w_rrange, w_ar_err, w_rerr_now;
  logic [MEM_AW-1:0] w_widx, w_ridx;
  logic              w_unused;

  // Byte-offset bits of the start addresses carry no meaning for 32-bit beats.
  assign w_unused = ^{axi.awaddr_i[1:0], axi.araddr_i[1:0]};

  assign w_wwoff      = r_wwaddr - c_base_w;
  assign w_wrange     = (r_wwaddr >= c_base_w) && (w_wwoff[29:MEM_AW] == '0);
  assign w_widx       = w_wwoff[MEM_AW-1:0];
  assign w_wlast_beat = (r_wcnt == r_wlen);
  assign w_wbeat_err  = (axi.wid_i != r_wid) || !w_wrange || (axi.wlast_i != w_wlast_beat);
  assign w_mem_we     = (r_wstate == W_DATA) && axi.wvalid_i && w_wrange && !r_wburst_err;
  assign w_aw_err     = (axi.awsize_i != 3'b010) || (axi.awburst_i != 2'b01);

  assign axi.awready_o = (r_wstate == W_IDLE);
  assign axi.wready_o  = (r_wstate == W_DATA);
  assign axi.bvalid_o  = (r_wstate == W_RESP);
  assign axi.bid_o     = r_bid;
  assign axi.bresp_o   = r_bresp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wstate     <= W_IDLE;
      r_wid        <= '0;
      r_wlen       <= '0;
      r_wcnt       <= '0;
      r_wwaddr     <= '0;
      r_wburst_err <= 1'b0;
      r_wsticky    <= 1'b0;
      r_bid        <= '0;
      r_bresp      <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: if (axi.awvalid_i) begin
          r_wid        <= axi.awid_i;
          r_wlen       <= axi.awlen_i;
          r_wcnt       <= '0;
          r_wwaddr     <= axi.awaddr_i[31:2];
          r_wburst_err <= w_aw_err;
          r_wsticky    <= w_aw_err;
          r_wstate     <= W_DATA;
        end
        W_DATA: if (axi.wvalid_i) begin
          r_wwaddr  <= r_wwaddr + 30'd1;
          r_wcnt    <= r_wcnt + 4'd1;
          r_wsticky <= r_wsticky | w_wbeat_err;
          // The beat count alone terminates the burst; a misplaced wlast only flags an error.
          if (w_wlast_beat) begin
            r_bid    <= r_wid;
            r_bresp  <= (r_wsticky || w_wbeat_err) ? 2'b10 : 2'b00;
            r_wstate <= W_RESP;
          end
        end
        W_RESP: if (axi.bready_i) r_wstate <= W_IDLE;
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (axi.wstrb_i[b]) r_mem[w_widx][8*b +: 8] <= axi.wdata_i[8*b +: 8];
      end
    end
  end

  // One address port serves both the AR load and the next-beat prefetch.
  assign w_rsel     = (r_rstate == R_IDLE) ? axi.araddr_i[31:2] : r_rwaddr + 30'd1;
  assign w_rwoff    = w_rsel - c_base_w;
  assign w_rrange   = (w_rsel >= c_base_w) && (w_rwoff[29:MEM_AW] == '0);
  assign w_ridx     = w_rwoff[MEM_AW-1:0];
  assign w_ar_err   = (axi.arsize_i != 3'b010) || (axi.arburst_i != 2'b01);
  assign w_rerr_now = (r_rstate == R_IDLE) ? w_ar_err : r_rburst_err;

  assign axi.arready_o = (r_rstate == R_IDLE);
  assign axi.rvalid_o  = r_rvalid;
  assign axi.rlast_o   = r_rlast;
  assign axi.rid_o     = r_rid;
  assign axi.rdata_o   = r_rdata;
  assign axi.rresp_o   = r_rresp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rstate     <= R_IDLE;
      r_rid        <= '0;
      r_rlen       <= '0;
      r_rcnt       <= '0;
      r_rwaddr     <= '0;
      r_rburst_err <= 1'b0;
      r_rvalid     <= 1'b0;
      r_rlast      <= 1'b0;
      r_rdata      <= '0;
      r_rresp      <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: if (axi.arvalid_i) begin
          r_rid        <= axi.arid_i;
          r_rlen       <= axi.arlen_i;
          r_rcnt       <= '0;
          r_rwaddr     <= w_rsel;
          r_rburst_err <= w_ar_err;
          r_rdata      <= (w_rrange && !w_rerr_now) ? r_mem[w_ridx] : 32'h0;
          r_rresp      <= (w_rrange && !w_rerr_now) ? 2'b00 : 2'b10;
          r_rlast      <= (axi.arlen_i == 4'd0);
          r_rvalid     <= 1'b1;
          r_rstate     <= R_DATA;
        end
        R_DATA: if (axi.rready_i) begin
          if (r_rlast) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            r_rstate <= R_IDLE;
          end else begin
            r_rwaddr <= w_rsel;
            r_rcnt   <= r_rcnt + 4'd1;
            r_rdata  <= (w_rrange && !w_rerr_now) ? r_mem[w_ridx] : 32'h0;
            r_rresp  <= (w_rrange && !w_rerr_now) ? 2'b00 : 2'b10;
            r_rlast  <= ((r_rcnt + 4'd1) == r_rlen);
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sgdmac_axi_mem_slave.sv
// ============================================================================
// Module      : tb_sgdmac_axi_mem_slave
// Description : Directed and randomized bursts against a word/byte memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sgdmac_axi_mem_slave;
  localparam int          MEM_AW = 8;
  localparam int          DEPTH  = 1 << MEM_AW;
  localparam logic [31:0] BASE   = 32'h0000_2000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sgdmac_axi_mem_slave_if bus ();
  sgdmac_axi_mem_slave #(.MEM_AW(MEM_AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .axi(bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] wr_data [16];
  logic [3:0]  wr_strb [16];
  int          wr_last_at = -1;
  logic [3:0]  wr_wid_xor = 4'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(BASE);
    return (off >= 0) && (off < 4 * DEPTH);
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE) >> 2;
    return int'(off) % DEPTH;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst, input int bdelay);
    int t;
    bit ok;
    bit err;
    logic [31:0] a;
    ok  = (size == 3'b010) && (burst == 2'b01);
    err = !ok;
    bus.awid_i = id; bus.awaddr_i = addr; bus.awlen_i = len[3:0];
    bus.awsize_i = size; bus.awburst_i = burst; bus.awvalid_i = 1'b1;
    t = 0;
    while (!bus.awready_o && t < 100) begin tick(); t++; end
    if (t >= 100) chk("aw_timeout", 32'd0, 32'd1);
    tick();
    bus.awvalid_i = 1'b0;
    for (int i = 0; i <= len; i++) begin
      a = addr + 32'(4 * i);
      bus.wid_i   = id ^ wr_wid_xor;
      bus.wdata_i = wr_data[i];
      bus.wstrb_i = wr_strb[i];
      bus.wlast_i = (wr_last_at < 0) ? (i == len) : (i == wr_last_at);
      bus.wvalid_i = 1'b1;
      t = 0;
      while (!bus.wready_o && t < 100) begin tick(); t++; end
      if (t >= 100) chk("w_timeout", 32'd0, 32'd1);
      if (!in_rng(a) || (bus.wlast_i != (i == len)) || (wr_wid_xor != 4'h0)) err = 1'b1;
      if (ok && in_rng(a))
        for (int b = 0; b < 4; b++)
          if (wr_strb[i][b]) model[widx(a)][8*b +: 8] = wr_data[i][8*b +: 8];
      tick();
    end
    bus.wvalid_i = 1'b0;
    bus.wlast_i  = 1'b0;
    chk("wready_after_burst", {31'd0, bus.wready_o}, 32'd0);
    for (int d = 0; d < bdelay; d++) begin
      chk("b_hold_bvalid", {31'd0, bus.bvalid_o}, 32'd1);
      chk("b_hold_awready", {31'd0, bus.awready_o}, 32'd0);
      tick();
    end
    bus.bready_i = 1'b1;
    t = 0;
    while (!bus.bvalid_o && t < 100) begin tick(); t++; end
    if (t >= 100) chk("b_timeout", 32'd0, 32'd1);
    chk("bid", {28'd0, bus.bid_o}, {28'd0, id});
    chk("bresp", {30'd0, bus.bresp_o}, err ? 32'd2 : 32'd0);
    tick();
    bus.bready_i = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input logic [2:0] size, input logic [1:0] burst, input bit toggle);
    int t;
    int beat;
    int cyc;
    bit ok;
    bit stalled;
    logic [31:0] a;
    logic [31:0] prev_data;
    logic        prev_last;
    logic [3:0]  prev_id;
    ok = (size == 3'b010) && (burst == 2'b01);
    bus.arid_i = id; bus.araddr_i = addr; bus.arlen_i = len[3:0];
    bus.arsize_i = size; bus.arburst_i = burst; bus.arvalid_i = 1'b1;
    t = 0;
    while (!bus.arready_o && t < 100) begin tick(); t++; end
    if (t >= 100) chk("ar_timeout", 32'd0, 32'd1);
    tick();
    bus.arvalid_i = 1'b0;
    chk("r_latency", {31'd0, bus.rvalid_o}, 32'd1);
    beat = 0; cyc = 0; stalled = 1'b0;
    prev_data = '0; prev_last = 1'b0; prev_id = '0;
    while (beat <= len && cyc < 400) begin
      if (stalled) begin
        chk("stall_rdata", bus.rdata_o, prev_data);
        chk("stall_rlast", {31'd0, bus.rlast_o}, {31'd0, prev_last});
        chk("stall_rid", {28'd0, bus.rid_o}, {28'd0, prev_id});
      end
      bus.rready_i = toggle ? (cyc % 2 == 0) : 1'b1;
      if (bus.rvalid_o && bus.rready_i) begin
        a = addr + 32'(4 * beat);
        chk("rdata", bus.rdata_o, (ok && in_rng(a)) ? model[widx(a)] : 32'h0);
        chk("rresp", {30'd0, bus.rresp_o}, (ok && in_rng(a)) ? 32'd0 : 32'd2);
        chk("rlast", {31'd0, bus.rlast_o}, (beat == len) ? 32'd1 : 32'd0);
        chk("rid", {28'd0, bus.rid_o}, {28'd0, id});
        beat++;
        stalled = 1'b0;
      end else if (bus.rvalid_o) begin
        stalled = 1'b1;
        prev_data = bus.rdata_o; prev_last = bus.rlast_o; prev_id = bus.rid_o;
      end
      tick();
      cyc++;
    end
    bus.rready_i = 1'b0;
    if (beat <= len) chk("r_timeout", 32'd0, 32'd1);
    chk("rvalid_after_last", {31'd0, bus.rvalid_o}, 32'd0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wa;
    logic [31:0] ra;
    int          len;
    bus.awid_i = '0; bus.awaddr_i = '0; bus.awlen_i = '0; bus.awsize_i = '0;
    bus.awburst_i = '0; bus.awvalid_i = 1'b0;
    bus.wid_i = '0; bus.wdata_i = '0; bus.wstrb_i = '0; bus.wlast_i = 1'b0; bus.wvalid_i = 1'b0;
    bus.bready_i = 1'b0;
    bus.arid_i = '0; bus.araddr_i = '0; bus.arlen_i = '0; bus.arsize_i = '0;
    bus.arburst_i = '0; bus.arvalid_i = 1'b0; bus.rready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_awready", {31'd0, bus.awready_o}, 32'd1);
    chk("rst_arready", {31'd0, bus.arready_o}, 32'd1);
    chk("rst_wready",  {31'd0, bus.wready_o},  32'd0);
    chk("rst_bvalid",  {31'd0, bus.bvalid_o},  32'd0);
    chk("rst_rvalid",  {31'd0, bus.rvalid_o},  32'd0);
    chk("rst_rlast",   {31'd0, bus.rlast_o},   32'd0);
    chk("rst_rdata",   bus.rdata_o, 32'd0);
    chk("rst_bresp",   {30'd0, bus.bresp_o}, 32'd0);

    // Fill the whole array with random words
    for (int k = 0; k < DEPTH / 16; k++) begin
      for (int i = 0; i < 16; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'hF; end
      do_write(4'(k), BASE + 32'(64 * k), 15, 3'b010, 2'b01, 0);
    end

    // Basic 4-beat write and readback
    for (int i = 0; i < 4; i++) begin wr_data[i] = 32'hA0 + 32'(i); wr_strb[i] = 4'hF; end
    do_write(4'h5, BASE + 32'h100, 3, 3'b010, 2'b01, 0);
    do_read(4'h6, BASE + 32'h100, 3, 3'b010, 2'b01, 1'b0);
    chk("direct_a0", model[widx(BASE + 32'h100)], 32'hA0);

    // Byte strobes
    wr_data[0] = 32'hFFFF_FFFF; wr_strb[0] = 4'hF;
    do_write(4'h1, BASE + 32'h40, 0, 3'b010, 2'b01, 0);
    wr_data[0] = 32'h1122_3344; wr_strb[0] = 4'b0101;
    do_write(4'h2, BASE + 32'h40, 0, 3'b010, 2'b01, 0);
    do_read(4'h3, BASE + 32'h40, 0, 3'b010, 2'b01, 1'b0);
    chk("strobe_merge", model[widx(BASE + 32'h40)], 32'hFF22_FF44);

    // Stalled 16-beat read, delayed B acceptance
    do_read(4'h7, BASE + 32'h200, 15, 3'b010, 2'b01, 1'b1);
    for (int i = 0; i < 2; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'hF; end
    do_write(4'h8, BASE + 32'h300, 1, 3'b010, 2'b01, 5);

    // Error bursts
    for (int i = 0; i < 4; i++) begin wr_data[i] = 32'hDEAD_0000 + 32'(i); wr_strb[i] = 4'hF; end
    do_write(4'h9, BASE + 32'h100, 3, 3'b001, 2'b01, 0);
    do_read(4'h9, BASE + 32'h100, 3, 3'b010, 2'b01, 1'b0);
    wr_last_at = 1;
    do_write(4'hA, BASE + 32'h180, 3, 3'b010, 2'b01, 0);
    wr_last_at = -1;
    wr_wid_xor = 4'h1;
    do_write(4'hB, BASE + 32'h1C0, 0, 3'b010, 2'b01, 0);
    wr_wid_xor = 4'h0;
    do_read(4'hC, BASE + 32'(4 * DEPTH), 0, 3'b010, 2'b01, 1'b0);
    do_read(4'hD, BASE - 32'd4, 1, 3'b010, 2'b01, 1'b0);
    do_read(4'hE, BASE + 32'(4 * DEPTH) - 32'd8, 3, 3'b010, 2'b01, 1'b0);
    do_read(4'hF, BASE + 32'h180, 1, 3'b010, 2'b00, 1'b0);

    // Same-word write and read load in one cycle
    wr_data[0] = 32'h33; wr_strb[0] = 4'hF;
    do_write(4'h1, BASE + 32'h80, 0, 3'b010, 2'b01, 0);
    bus.awid_i = 4'h2; bus.awaddr_i = BASE + 32'h80; bus.awlen_i = 4'd0;
    bus.awsize_i = 3'b010; bus.awburst_i = 2'b01; bus.awvalid_i = 1'b1;
    tick();
    bus.awvalid_i = 1'b0;
    chk("rw_wready", {31'd0, bus.wready_o}, 32'd1);
    bus.wid_i = 4'h2; bus.wdata_i = 32'h55; bus.wstrb_i = 4'hF; bus.wlast_i = 1'b1; bus.wvalid_i = 1'b1;
    bus.arid_i = 4'h3; bus.araddr_i = BASE + 32'h80; bus.arlen_i = 4'd0;
    bus.arsize_i = 3'b010; bus.arburst_i = 2'b01; bus.arvalid_i = 1'b1;
    tick();
    bus.wvalid_i = 1'b0; bus.wlast_i = 1'b0; bus.arvalid_i = 1'b0;
    model[widx(BASE + 32'h80)] = 32'h55;
    chk("rw_old_data", bus.rdata_o, 32'h33);
    chk("rw_rvalid", {31'd0, bus.rvalid_o}, 32'd1);
    chk("rw_bvalid", {31'd0, bus.bvalid_o}, 32'd1);
    bus.rready_i = 1'b1; bus.bready_i = 1'b1;
    tick();
    bus.rready_i = 1'b0; bus.bready_i = 1'b0;
    do_read(4'h4, BASE + 32'h80, 0, 3'b010, 2'b01, 1'b0);
    chk("rw_new_model", model[widx(BASE + 32'h80)], 32'h55);

    // Reset during beat 3 of an 8-beat read
    bus.arid_i = 4'h5; bus.araddr_i = BASE; bus.arlen_i = 4'd7;
    bus.arsize_i = 3'b010; bus.arburst_i = 2'b01; bus.arvalid_i = 1'b1;
    tick();
    bus.arvalid_i = 1'b0;
    bus.rready_i = 1'b1;
    repeat (3) tick();
    bus.rready_i = 1'b0;
    chk("pre_rst_rdata", bus.rdata_o, model[widx(BASE + 32'd12)]);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", {31'd0, bus.rvalid_o}, 32'd0);
    chk("mid_rst_arready", {31'd0, bus.arready_o}, 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    do_read(4'h6, BASE + 32'h100, 3, 3'b010, 2'b01, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 24; n++) begin
      len = int'($urandom_range(0, 15));
      wa  = BASE + 32'(4 * $urandom_range(0, DEPTH + 4)) - (($urandom % 6 == 0) ? 32'd16 : 32'd0);
      for (int i = 0; i < 16; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'($urandom); end
      do_write(4'($urandom), wa, len, ($urandom % 8 == 0) ? 3'b001 : 3'b010,
               ($urandom % 8 == 0) ? 2'b10 : 2'b01, int'($urandom_range(0, 2)));
      len = int'($urandom_range(0, 15));
      ra  = BASE + 32'(4 * $urandom_range(0, DEPTH + 4));
      do_read(4'($urandom), ra, len, ($urandom % 8 == 0) ? 3'b011 : 3'b010, 2'b01,
              1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
